// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) sequencer for a single-port synchronous RAM.
// Define ARB_FAIR_EN to alternate grants under contention; otherwise D has fixed priority over IF.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;       // 1 = D port, 0 = IF port
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic                d_err_q, d_err_d;
`ifdef ARB_FAIR_EN
    logic                ptr_q, ptr_d;           // last granted port
`endif

    logic                gnt_d_port;
    logic                gnt_any;
    logic                sel_we;
    logic                sel_oor;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
`ifdef ARB_FAIR_EN
        if (d_req && if_req) begin
            gnt_d_port = ~ptr_q;
        end else begin
            gnt_d_port = d_req;
        end
`else
        gnt_d_port = d_req;
`endif
        // A completion pulse on the outputs marks the bubble cycle: no grant then.
        gnt_any   = (d_req | if_req) & ~if_valid_q & ~d_valid_q;
        sel_addr  = gnt_d_port ? d_addr : if_addr;
        sel_we    = gnt_d_port & d_we;
        sel_wdata = gnt_d_port ? d_wdata : '0;
        sel_oor   = (sel_addr >= ADDR_W'(DEPTH));
        rd_word   = oor_q ? '0 : ram_rdata;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        ram_en_d    = ram_en_q;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
`ifdef ARB_FAIR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    owner_d     = gnt_d_port;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    ram_en_d    = ~sel_oor;
                    ram_rw_d    = sel_we & ~sel_oor;
                    ram_addr_d  = sel_addr;
                    ram_wdata_d = sel_wdata;
`ifdef ARB_FAIR_EN
                    ptr_d       = gnt_d_port;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ram_en_d = 1'b0;
                ram_rw_d = 1'b0;
                state_d  = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (owner_q) begin
                    d_rdata_d = rd_word;
                end else begin
                    if_rdata_d = rd_word;
                end
                state_d = DONE;
            end
            DONE: begin
                if (owner_q) begin
                    d_valid_d = 1'b1;
                    d_err_d   = oor_q;
                end else begin
                    if_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
`ifdef ARB_FAIR_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            ram_en_q    <= ram_en_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
`ifdef ARB_FAIR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign stall     = d_req & ~d_valid_q;

endmodule
